// File: rtl/ads8688_spi_resp.sv
// SPI target that mimics the ADS8688 frame: a 16-bit command on MOSI, then 16 bits of data on MISO.
// All SPI pins are synchronized into the clk domain. The frame logic is a single registered state machine.
module ads8688_spi_resp (
   input  logic        clk,
   input  logic        rst,
   input  logic        sclk,
   input  logic        csn,
   input  logic        mosi,
   output logic        miso,
   output logic        cmd_valid,
   output logic [15:0] cmd_word,
   output logic [2:0]  cur_ch,
   output logic        frame_err
);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_CMD  = 2'd1,
      S_DATA = 2'd2,
      S_HOLD = 2'd3
   } state_t;

   logic        r_sclk_s1, r_sclk_s2, r_sclk_d;
   logic        r_csn_s1, r_csn_s2;
   logic        r_mosi_s1, r_mosi_s2;
   logic [1:0]  r_sync_vld;
   logic        r_armed;
   state_t      r_state;
   logic [4:0]  r_fcnt;
   logic [15:0] r_shift;
   logic [12:0] r_conv;
   logic [15:0] r_tx;
   logic        r_miso;
   logic        r_cmd_valid;
   logic [15:0] r_cmd_word;
   logic [2:0]  r_cur_ch;
   logic        r_frame_err;

   logic        w_sclk_fall;
   logic        w_sclk_rise;
   logic [15:0] w_cmd_next;

   // Manual-channel words select a channel, the program reset word returns to channel 0, and other words keep it.
   function automatic logic [2:0] decode_ch(input logic [15:0] cmd, input logic [2:0] cur);
      logic [2:0] ch;
      if ((cmd[15:13] == 3'b110) && (cmd[9:0] == 10'd0)) begin
         ch = cmd[12:10];
      end else if (cmd == 16'h8500) begin
         ch = 3'd0;
      end else begin
         ch = cur;
      end
      return ch;
   endfunction

   assign w_sclk_fall = r_sclk_d & ~r_sclk_s2;
   assign w_sclk_rise = ~r_sclk_d & r_sclk_s2;
   assign w_cmd_next  = {r_shift[14:0], r_mosi_s2};

   // Two-flop synchronizers and the sclk edge-detect delay.
   // r_sync_vld marks when r_csn_s2 holds a real pin sample rather than its reset value.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_sclk_s1  <= 1'b0;
         r_sclk_s2  <= 1'b0;
         r_sclk_d   <= 1'b0;
         r_csn_s1   <= 1'b1;
         r_csn_s2   <= 1'b1;
         r_mosi_s1  <= 1'b0;
         r_mosi_s2  <= 1'b0;
         r_sync_vld <= 2'b00;
      end else begin
         r_sclk_s1  <= sclk;
         r_sclk_s2  <= r_sclk_s1;
         r_sclk_d   <= r_sclk_s2;
         r_csn_s1   <= csn;
         r_csn_s2   <= r_csn_s1;
         r_mosi_s1  <= mosi;
         r_mosi_s2  <= r_mosi_s1;
         r_sync_vld <= {r_sync_vld[0], 1'b1};
      end
   end

   // Frame state machine with all registered outputs.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_armed     <= 1'b0;
         r_state     <= S_IDLE;
         r_fcnt      <= 5'd0;
         r_shift     <= 16'h0000;
         r_conv      <= 13'd0;
         r_tx        <= 16'h0000;
         r_miso      <= 1'b0;
         r_cmd_valid <= 1'b0;
         r_cmd_word  <= 16'h0000;
         r_cur_ch    <= 3'd0;
         r_frame_err <= 1'b0;
      end else begin
         r_cmd_valid <= 1'b0;
         r_frame_err <= 1'b0;
         if (r_sync_vld[1] && r_csn_s2) begin
            r_armed <= 1'b1;
         end else begin
            r_armed <= r_armed;
         end
         case (r_state)
            S_IDLE: begin
               r_miso <= 1'b0;
               // A frame starts only after csn has really been sampled high, so a frame cut by reset is ignored.
               if (r_armed && r_sync_vld[1] && !r_csn_s2) begin
                  r_state <= S_CMD;
                  r_armed <= 1'b0;
                  r_fcnt  <= 5'd0;
                  r_shift <= 16'h0000;
                  r_tx    <= {r_cur_ch, r_conv};
                  r_conv  <= r_conv + 13'd1;
               end else begin
                  r_state <= S_IDLE;
               end
            end
            S_CMD: begin
               r_miso <= 1'b0;
               if (r_csn_s2) begin
                  r_state     <= S_IDLE;
                  r_frame_err <= (r_fcnt != 5'd0);
               end else if (w_sclk_fall) begin
                  r_shift <= w_cmd_next;
                  if (r_fcnt == 5'd15) begin
                     r_state     <= S_DATA;
                     r_fcnt      <= 5'd16;
                     r_cmd_word  <= w_cmd_next;
                     r_cmd_valid <= 1'b1;
                     r_cur_ch    <= decode_ch(w_cmd_next, r_cur_ch);
                  end else begin
                     r_fcnt <= r_fcnt + 5'd1;
                  end
               end else begin
                  r_state <= S_CMD;
               end
            end
            S_DATA: begin
               if (r_csn_s2) begin
                  r_state     <= S_IDLE;
                  r_miso      <= 1'b0;
                  r_frame_err <= 1'b1;
               end else if (w_sclk_fall) begin
                  if (r_fcnt == 5'd31) begin
                     r_state <= S_HOLD;
                     r_miso  <= 1'b0;
                  end else begin
                     r_fcnt <= r_fcnt + 5'd1;
                  end
               end else if (w_sclk_rise) begin
                  r_miso <= r_tx[15];
                  r_tx   <= {r_tx[14:0], 1'b0};
               end else begin
                  r_state <= S_DATA;
               end
            end
            S_HOLD: begin
               r_miso <= 1'b0;
               if (r_csn_s2) begin
                  r_state <= S_IDLE;
               end else begin
                  r_state <= S_HOLD;
               end
            end
            default: begin
               r_state <= S_IDLE;
               r_miso  <= 1'b0;
            end
         endcase
      end
   end

   assign miso      = r_miso;
   assign cmd_valid = r_cmd_valid;
   assign cmd_word  = r_cmd_word;
   assign cur_ch    = r_cur_ch;
   assign frame_err = r_frame_err;

endmodule

// File: tb/tb_ads8688_spi_resp.sv
// Directed bench for ads8688_spi_resp. Commands are queued when sent and matched against each cmd_valid pulse.
module tb_ads8688_spi_resp;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        sclk = 1'b0;
   logic        csn = 1'b1;
   logic        mosi = 1'b0;
   logic        miso;
   logic        cmd_valid;
   logic [15:0] cmd_word;
   logic [2:0]  cur_ch;
   logic        frame_err;

   int          checks = 0;
   int          errors = 0;
   int          n_valid = 0;
   int          n_err = 0;
   logic [15:0] exp_q[$];
   logic [15:0] exp_cmd;

   ads8688_spi_resp dut (
      .clk       (clk),
      .rst       (rst),
      .sclk      (sclk),
      .csn       (csn),
      .mosi      (mosi),
      .miso      (miso),
      .cmd_valid (cmd_valid),
      .cmd_word  (cmd_word),
      .cur_ch    (cur_ch),
      .frame_err (frame_err)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed %h expected %h", tag, obs, exp);
      end
   endtask

   // Each cmd_valid pulse must match the oldest command still waiting in the queue.
   always @(negedge clk) begin
      if (frame_err === 1'b1) n_err++;
      if (cmd_valid === 1'b1) begin
         n_valid++;
         if (exp_q.size() == 0) begin
            check("cmd_unexpected", 32'd1, 32'd0);
         end else begin
            exp_cmd = exp_q.pop_front();
            check("cmd_word", 32'(cmd_word), 32'(exp_cmd));
         end
      end
   end

   // Drives one frame with nfall sclk periods. MISO is sampled just before each falling edge from 17 to 32.
   task automatic spi_frame(input logic [15:0] cmd, input int nfall, output logic [15:0] rx);
      rx = 16'h0000;
      if (nfall >= 16) exp_q.push_back(cmd);
      csn = 1'b0;
      #80;
      for (int i = 0; i < nfall; i++) begin
         mosi = (i < 16) ? cmd[15 - i] : 1'b0;
         sclk = 1'b1;
         #40;
         if (i >= 16) rx = {rx[14:0], miso};
         sclk = 1'b0;
         #40;
      end
      mosi = 1'b0;
      #40;
      csn = 1'b1;
      #100;
   endtask

   logic [15:0] rx;
   int          v0, e0;

   initial begin
      repeat (4) @(negedge clk);
      check("rst_miso", 32'(miso), 32'd0);
      check("rst_cmd_valid", 32'(cmd_valid), 32'd0);
      check("rst_cmd_word", 32'(cmd_word), 32'h0000);
      check("rst_cur_ch", 32'(cur_ch), 32'd0);
      check("rst_frame_err", 32'(frame_err), 32'd0);
      rst = 1'b0;
      repeat (4) @(negedge clk);

      v0 = n_valid;
      spi_frame(16'hC400, 32, rx);
      check("f1_valid_cnt", 32'(n_valid - v0), 32'd1);
      check("f1_cur_ch", 32'(cur_ch), 32'd1);
      check("f1_data", 32'(rx), 32'h0000);
      check("f1_miso_idle", 32'(miso), 32'd0);

      spi_frame(16'h0000, 32, rx);
      check("f2_cur_ch", 32'(cur_ch), 32'd1);
      check("f2_data", 32'(rx), 32'h2001);

      spi_frame(16'hDC00, 32, rx);
      check("f3_cur_ch", 32'(cur_ch), 32'd7);
      check("f3_data", 32'(rx), 32'h2002);
      spi_frame(16'h8500, 32, rx);
      check("f4_cur_ch", 32'(cur_ch), 32'd0);
      check("f4_data", 32'(rx), 32'hE003);
      check("f4_data_ch", 32'(rx[15:13]), 32'd7);

      v0 = n_valid;
      e0 = n_err;
      spi_frame(16'hC800, 10, rx);
      check("short10_err", 32'(n_err - e0), 32'd1);
      check("short10_valid", 32'(n_valid - v0), 32'd0);
      check("short10_cur_ch", 32'(cur_ch), 32'd0);
      v0 = n_valid;
      e0 = n_err;
      spi_frame(16'hC800, 20, rx);
      check("short20_err", 32'(n_err - e0), 32'd1);
      check("short20_valid", 32'(n_valid - v0), 32'd1);
      check("short20_cur_ch", 32'(cur_ch), 32'd2);

      // Six frames have been started so far. These empty frames advance conv_cnt to its wrap point.
      e0 = n_err;
      for (int k = 0; k < 8186; k++) begin
         csn = 1'b0;
         #30;
         csn = 1'b1;
         #30;
      end
      #100;
      check("wrap_no_err", 32'(n_err - e0), 32'd0);
      spi_frame(16'h0000, 32, rx);
      check("wrap_data", 32'(rx), 32'h4000);
      check("wrap_low13", 32'(rx[12:0]), 32'd0);

      // Reset arrives at the 8th falling edge and is released while csn is still low.
      v0 = n_valid;
      e0 = n_err;
      csn = 1'b0;
      #80;
      for (int i = 0; i < 32; i++) begin
         mosi = (i < 16) ? exp_cmd_bit(i) : 1'b0;
         sclk = 1'b1;
         #40;
         sclk = 1'b0;
         if (i == 7) rst = 1'b1;
         if (i == 9) begin
            check("mid_rst_miso", 32'(miso), 32'd0);
            check("mid_rst_cmd_word", 32'(cmd_word), 32'h0000);
            check("mid_rst_cur_ch", 32'(cur_ch), 32'd0);
            check("mid_rst_cmd_valid", 32'(cmd_valid), 32'd0);
            check("mid_rst_frame_err", 32'(frame_err), 32'd0);
            rst = 1'b0;
         end
         #40;
      end
      mosi = 1'b0;
      #40;
      csn = 1'b1;
      #100;
      check("after_rst_valid", 32'(n_valid - v0), 32'd0);
      check("after_rst_err", 32'(n_err - e0), 32'd0);
      check("after_rst_cur_ch", 32'(cur_ch), 32'd0);

      spi_frame(16'hC400, 32, rx);
      check("post_rst_cur_ch", 32'(cur_ch), 32'd1);
      check("post_rst_cmd_word", 32'(cmd_word), 32'hC400);
      check("post_rst_data", 32'(rx), 32'h0000);
      check("queue_empty", 32'(exp_q.size()), 32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   function automatic logic exp_cmd_bit(input int i);
      logic [15:0] w;
      w = 16'hC400;
      return w[15 - i];
   endfunction

endmodule

// File: doc/ads8688_spi_resp.md
ADS8688_SPI_RESP -- requirements
Module: ads8688_spi_resp

Interface
REQ-001 SHALL have a single clock and a synchronous, active-high reset; every flop is clocked by clk and reset only by rst on a clk rising edge.
REQ-002 clk  input  1  system clock; SHALL be at least 4x the sclk frequency.
REQ-003 rst  input  1  synchronous active-high reset.
REQ-004 sclk  input  1  SPI clock from the controller, idle low, asynchronous to clk.
REQ-005 csn  input  1  active-low frame select, asynchronous to clk.
REQ-006 mosi  input  1  command bits, MSB first.
REQ-007 miso  output  1  conversion data, MSB first; driven 0 whenever csn is high (no tristate).
REQ-008 cmd_valid  output  1  one-clk pulse when a 16-bit command has been received.
REQ-009 cmd_word  output  16  last received command; held until the next cmd_valid.
REQ-010 cur_ch  output  3  currently selected manual channel.
REQ-011 frame_err  output  1  one-clk pulse when csn rises with the falling-edge count not equal to 0 and below 32.

Function
REQ-012 sclk, csn and mosi SHALL each pass through a 2-flop synchronizer; edges are detected from the synchronized sclk and csn.
REQ-013 State machine states: IDLE, CMD, DATA, HOLD.
- IDLE -> CMD on a synchronized csn falling edge.
- CMD -> DATA after the 16th sclk falling edge.
- DATA -> HOLD after the 32nd falling edge.
- Any state -> IDLE on a csn rising edge.
REQ-014 mosi SHALL be sampled on each detected sclk falling edge into a 16-bit shift register; a 5-bit falling-edge counter SHALL run 0..31 within the frame.
REQ-015 At the 16th falling edge, the device SHALL:
- load cmd_word with the shifted value;
- pulse cmd_valid in the same clk as the transition to DATA;
- decode the command per REQ-016.
REQ-016 Command decode:
- 16'hC000 | (n<<10) for n=0..7 (manual channel n): cur_ch <= n.
- 16'h8500 (reset program registers): cur_ch <= 0.
- 16'h0000 (no-op) and all other words: cur_ch unchanged.
All decoded commands SHALL still pulse cmd_valid.
REQ-017 On a csn falling edge, a 13-bit conv_cnt and the data word SHALL update as follows:
- data word <= {cur_ch, conv_cnt}, using the pre-increment conv_cnt;
- conv_cnt then increments, wrapping 8191 -> 0.
Data returned in frame N therefore reflects the channel chosen by the command in frame N-1.
REQ-018 miso output timing:
- miso SHALL be 0 in CMD.
- On the sclk rising edge following the 16th falling edge, miso SHALL present data bit 15.
- Each subsequent rising edge SHALL shift out the next bit, down to bit 0.
- miso SHALL be 0 in HOLD and IDLE.
REQ-019 miso SHALL change within 3 clk cycles of the sclk rising edge (2 sync + 1 register).
REQ-020 sclk edges after the 32nd edge SHALL be ignored; the counter SHALL NOT wrap within a frame.
REQ-021 Early csn rise:
- with count 1..15: no command applied, cur_ch unchanged, frame_err pulses;
- with count 16..31: the command already applied stands, frame_err pulses;
- with count 0 or 32: no frame_err.
REQ-022 A csn falling edge SHALL be accepted only from IDLE; csn must be seen high for at least one synchronized sample after reset or after a frame.

Reset
REQ-023 Reset values:
- miso=0, cmd_valid=0, cmd_word=16'h0000, cur_ch=0, frame_err=0;
- conv_cnt=0, counter=0, shift registers=0;
- state=IDLE and synchronizer flops at idle values (csn=1, sclk=0, mosi=0).
REQ-024 A reset asserted mid-frame SHALL abort the frame without a cmd_valid or frame_err pulse; the block SHALL ignore the remainder of that frame until csn has been seen high.

Verification
REQ-025 Bench SHALL cover the following scenarios:
- Frame 1 with command 16'hC400 -> cmd_valid pulses once, cmd_word=16'hC400, cur_ch=1; miso bits 16..31 read 16'h0000 (channel 0, conv_cnt 0).
- Frame 2 with command 16'h0000 after 16'hC400 -> cur_ch stays 1; miso data reads 16'h2001.
- Frame with 16'hDC00, then a frame with 16'h8500 -> cur_ch=7, then cur_ch=0; the data in the second frame has upper 3 bits 3'b111.
- csn raised after 10 falling edges of a 16'hC800 frame -> frame_err pulses, cur_ch unchanged, no cmd_valid; csn raised after 20 edges -> frame_err pulses and cur_ch=2.
- 8192 complete frames -> conv_cnt wraps; the 8193rd frame returns data low 13 bits = 0.
- rst asserted at falling edge 8 of a frame, released while csn is still low -> all outputs at reset values; no response until csn rises and falls again.
